// File: rtl/serial_rx_fifo_pkg.sv
// Shared types and constants for the UART receive byte buffer.
package serial_rx_fifo_pkg;
  typedef enum logic {
    SRF_ST_WAIT = 1'b0,
    SRF_ST_ACK  = 1'b1
  } srf_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO; head word is masked to zero when empty.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a push into a full FIFO is only legal when a pop frees the slot this cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/serial_rx_fifo.sv
// Receive buffer behind serial_rx: 4-phase capture handshake, FWFT storage,
// sticky overflow and an end-of-line pulse on a stored carriage return.
module serial_rx_fifo
  import serial_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_finish,
  output logic          rx_ready,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          eol
);
  // state | meaning
  // WAIT  | idle, next rx_finish high captures one byte
  // ACK   | byte taken, rx_ready held until rx_finish drops
  srf_state_e state;
  srf_state_e state_nxt;
  logic       capture;
  logic       accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SRF_ST_WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      SRF_ST_WAIT: begin
        if (rx_finish) begin
          capture   = 1'b1;
          state_nxt = SRF_ST_ACK;
        end
      end
      SRF_ST_ACK: begin
        if (!rx_finish) state_nxt = SRF_ST_WAIT;
      end
      default: state_nxt = SRF_ST_WAIT;
    endcase
  end

  // rx_ready is high exactly while the FSM sits in ACK, so it tracks the register
  assign rx_ready = (state == SRF_ST_ACK);
  assign accept   = capture && (!full || rd_en);

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (rd_en),
    .din   (rx_data),
    .dout  (rd_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      eol      <= 1'b0;
    end else begin
      if (capture && !accept) overflow <= 1'b1;
      else if (ovf_clr)       overflow <= 1'b0;
      eol <= accept && (rx_data == ASCII_CR);
    end
  end
endmodule

// File: tb/tb_serial_rx_fifo.sv
// Self-checking bench for serial_rx_fifo: table-driven single byte, directed
// corner sequences and randomized traffic against a queue-based reference.
module tb_serial_rx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_finish = 1'b0;
  logic       rx_ready;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       ovf_clr = 1'b0;
  logic       eol;

  int errors = 0;
  int checks = 0;

  // reference state: stored bytes, handshake-in-progress flag, flags
  logic [7:0] q[$];
  bit         m_busy;
  bit         m_ovf;
  bit         m_eol;

  serial_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_finish (rx_finish),
    .rx_ready  (rx_ready),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .eol       (eol)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 1'b0;
    m_ovf  = 1'b0;
    m_eol  = 1'b0;
  endtask

  task automatic check_model();
    chk("rx_ready", rx_ready, m_busy);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == 16);
    chk("rd_data", rd_data, (q.size() == 0) ? 8'h00 : q[0]);
    chk("overflow", overflow, m_ovf);
    chk("eol", eol, m_eol);
  endtask

  task automatic tick();
    bit cap;
    bit pop_ok;
    bit acc;
    @(posedge clk);
    cap    = rx_finish && !m_busy;
    pop_ok = rd_en && (q.size() > 0);
    acc    = cap && ((q.size() < 16) || pop_ok);
    if (pop_ok) void'(q.pop_front());
    if (acc) q.push_back(rx_data);
    m_busy = cap ? 1'b1 : (m_busy && rx_finish);
    m_eol  = acc && (rx_data == 8'h0D);
    if (cap && !acc) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    #1;
    check_model();
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int hold, input bit rd_cap, input bit clr_cap);
    rx_data   = d;
    rx_finish = 1'b1;
    rd_en     = rd_cap;
    ovf_clr   = clr_cap;
    tick();
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    repeat (hold - 1) tick();
    rx_finish = 1'b0;
    tick();
  endtask

  task automatic drain();
    rd_en = 1'b1;
    for (int i = 0; i < 20 && count != 0; i++) tick();
    rd_en = 1'b0;
    chk("drain_empty", empty, 1'b1);
  endtask

  task automatic fill16(input logic [7:0] base);
    for (int i = 0; i < 16 && !full; i++) send_byte(base + 8'(i), 1, 1'b0, 1'b0);
    chk("fill_full", full, 1'b1);
  endtask

  typedef struct {
    logic       fin;
    logic [7:0] data;
    logic       rd;
    logic       e_ready;
    logic [4:0] e_count;
    logic [7:0] e_rd_data;
  } vec_t;
  vec_t vt[5];

  initial begin
    model_reset();
    #3;
    check_model();
    @(posedge clk);
    #1 rst = 1'b0;

    // single byte, finish held three cycles
    vt[0] = '{1'b1, 8'h41, 1'b0, 1'b1, 5'd1, 8'h41};
    vt[1] = '{1'b1, 8'h41, 1'b0, 1'b1, 5'd1, 8'h41};
    vt[2] = '{1'b1, 8'h41, 1'b0, 1'b1, 5'd1, 8'h41};
    vt[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 8'h41};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00};
    for (int i = 0; i < 5; i++) begin
      rx_finish = vt[i].fin;
      rx_data   = vt[i].data;
      rd_en     = vt[i].rd;
      tick();
      chk("tbl_ready", rx_ready, vt[i].e_ready);
      chk("tbl_count", count, vt[i].e_count);
      chk("tbl_rd_data", rd_data, vt[i].e_rd_data);
    end
    rd_en = 1'b0;

    // long finish: one write only
    send_byte(8'h5A, 50, 1'b0, 1'b0);
    chk("long_count", count, 5'd1);
    drain();

    // fill then overflow, then read back in order
    fill16(8'h00);
    send_byte(8'hAA, 2, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count", count, 5'd16);
    chk("ovf_ready_low", rx_ready, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("pop_order", rd_data, i);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    chk("pop_empty", empty, 1'b1);
    chk("pop_rd_zero", rd_data, 8'h00);

    // full with simultaneous pop accepts the byte
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);
    fill16(8'h20);
    send_byte(8'hBB, 1, 1'b1, 1'b0);
    chk("pp_ovf", overflow, 1'b0);
    chk("pp_count", count, 5'd16);
    chk("pp_head", rd_data, 8'h21);
    drain();

    // eol pulse on a stored CR
    rx_data   = 8'h0D;
    rx_finish = 1'b1;
    tick();
    chk("eol_pulse", eol, 1'b1);
    rx_finish = 1'b0;
    tick();
    chk("eol_once", eol, 1'b0);
    fill16(8'h30);
    rx_data   = 8'h0D;
    rx_finish = 1'b1;
    tick();
    chk("eol_drop", eol, 1'b0);
    chk("eol_drop_ovf", overflow, 1'b1);
    rx_finish = 1'b0;
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr2", overflow, 1'b0);
    send_byte(8'h77, 1, 1'b0, 1'b1);
    chk("ovf_set_prio", overflow, 1'b1);
    drain();

    // reset while in ACK with finish still high
    apply_reset();
    send_byte(8'h11, 1, 1'b0, 1'b0);
    rx_data   = 8'h55;
    rx_finish = 1'b1;
    tick();
    tick();
    chk("rst_pre_ready", rx_ready, 1'b1);
    apply_reset();
    chk("rst_ready", rx_ready, 1'b0);
    chk("rst_count", count, 5'd0);
    tick();
    chk("recap_count", count, 5'd1);
    chk("recap_data", rd_data, 8'h55);
    rx_finish = 1'b0;
    tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) rx_finish = ~rx_finish;
      rx_data = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom);
      rd_en   = ($urandom_range(0, 9) < ((i % 200 < 100) ? 2 : 6));
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
